multicycle_control: RTL
=======================

# multicycle_control

Control FSM for the multicycle core: sequences instruction fetch, decode, execute, memory access and writeback over the shared ALU, register file, PC/old-PC/IR/MDR/ALUOut registers and the single memory port. It reads the opcode and funct3 from IR, the ALU zero flag and the memory ready handshake. It drives every datapath enable and mux select, including the IMM operand fed by the immediate generator. It also counts retired instructions and raises a sticky trap on illegal opcodes or memory timeouts.

## Interface
- MEM_TIMEOUT, 255: maximum cycles mem_req may wait for mem_ready; 0 disables the timeout.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut.
- ir_write, pc_write, oldpc_write, mdr_write  out  1 each  register enables.
- alu_src_a  out  2  0 = PC, 1 = OLD_PC, 2 = RS1.
- alu_src_b  out  2  0 = RS2, 1 = const 4, 2 = IMM.
- alu_op  out  2  0 = ADD, 1 = SUB, 2 = FUNCT (decode funct3).
- pc_src  out  1  0 = ALU result, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  retired-instruction count, wraps at 2^32.
- trap  out  1  sticky trap.
- trap_cause  out  2  01 = illegal opcode, 10 = memory timeout.

## Operation
- Opcodes handled: OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 (BEQ), JAL 1101111. Any other opcode is illegal.
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_I, ALU_WB, BRANCH, JAL, TRAP.
- Unlisted outputs are 0 in every state.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, alu_src_a=PC, alu_src_b=4, ADD.
  - On mem_ready: ir_write, pc_write (pc_src=0), oldpc_write, then go to DECODE.
- DECODE: alu_src_a=OLD_PC, alu_src_b=IMM, ADD; ALUOut captures the branch/jump target.
  - Next state: LOAD/STORE → MEM_ADDR; OP-IMM → EXEC_I; BRANCH → BRANCH; JAL → JAL; other → TRAP with cause 01.
- MEM_ADDR: RS1 + IMM, ADD. Next state: LOAD → MEM_READ, STORE → MEM_WRITE.
- MEM_READ: mem_req=1, mem_we=0, mem_addr_sel=1. On mem_ready: mdr_write, then MEM_WB.
- MEM_WB: reg_write, wb_sel=MDR, retire, then FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, mem_addr_sel=1. On mem_ready: retire, then FETCH.
- EXEC_I: alu_src_a=RS1, alu_src_b=IMM, alu_op=FUNCT, then ALU_WB.
- ALU_WB: reg_write, wb_sel=ALUOut, retire, then FETCH.
- BRANCH: RS1 vs RS2, SUB.
  - If alu_zero: pc_write with pc_src=ALUOut.
  - retire, then FETCH.
- JAL: reg_write with wb_sel=PC (PC already holds PC+4), pc_write with pc_src=ALUOut, retire, then FETCH.
- TRAP: trap=1 with trap_cause held; no further requests or writes. Only reset exits TRAP.
- Memory handshake:
  - mem_req, mem_we and the address select stay stable from assertion until the cycle mem_ready is sampled high.
  - mem_ready is ignored while mem_req=0.
- Wait counter: cleared on entry to FETCH, MEM_READ and MEM_WRITE; increments each cycle mem_req=1 and mem_ready=0. If it reaches MEM_TIMEOUT (MEM_TIMEOUT≠0): go to TRAP with cause 10, and mem_req drops on the next cycle.
- instret increments by 1 on every retire pulse.

## Timing
- The state register, instret, the wait counter and the trap registers reset asynchronously: state=RESET, instret=0, trap=0, trap_cause=00, counter=0. Every output is 0 during and in the first cycle after reset.
- Outputs are decoded from the state. pc_write, ir_write, oldpc_write and mdr_write additionally depend on mem_ready/alu_zero in the same cycle.
- Cycles per instruction with zero-wait memory (mem_ready high in the first request cycle):
  - OP-IMM: 4.
  - LOAD: 5.
  - STORE: 4.
  - BEQ: 3.
  - JAL: 3.
  - Each wait cycle adds 1.
- If mem_ready arrives on the same cycle the counter hits MEM_TIMEOUT, mem_ready wins and the access completes normally.
- Reset asserted mid-instruction: the FSM returns to RESET immediately, and mem_req drops asynchronously.

## Structure
- Shared header decode_defs.vh holds:
  - opcode constants (also used by the immediate generator);
  - state encodings (4-bit);
  - alu_src_a/b, alu_op, wb_sel and pc_src codes;
  - trap cause codes.
- One sub-module, mem_wait_timer: clear, count enable, MEM_TIMEOUT compare, expired output.

## Test plan
- OP-IMM 0x00500093 (addi x1,x0,5), mem_ready always high → reg_write in cycle 4 with wb_sel=0; retire=1 once; instret 0→1.
- LOAD with mem_ready delayed 3 cycles in MEM_READ → mem_req and mem_addr_sel=1 stable for 4 cycles, mdr_write in cycle 4 of MEM_READ, total 8 cycles.
- BEQ with alu_zero=1 → pc_write=1, pc_src=1 in BRANCH; with alu_zero=0 → pc_write=0; both take 3 cycles and retire.
- JAL → in one cycle: reg_write=1, wb_sel=2, pc_write=1, pc_src=1; next state FETCH.
- Illegal opcode 0x7F → trap=1, trap_cause=01 after DECODE; no mem_req afterwards; rst_n low clears trap and instret.
- MEM_TIMEOUT=4 with mem_ready held low in FETCH → TRAP with cause 10 after 4 waiting cycles; mem_ready on the 4th cycle instead completes the fetch normally.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared decode definitions for the multicycle core controller:
// opcodes, state encoding, datapath mux codes and trap causes.
package multicycle_control_pkg;

    // Opcodes (also consumed by the immediate generator)
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_TRAP      = 4'd11
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_SUB    = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    localparam logic       PC_SRC_ALU    = 1'b0;
    localparam logic       PC_SRC_ALUOUT = 1'b1;

    localparam logic [1:0] WB_ALUOUT  = 2'd0;
    localparam logic [1:0] WB_MDR     = 2'd1;
    localparam logic [1:0] WB_PC      = 2'd2;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // States that hold a memory request open and may wait on mem_ready
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Single memory port handshake between the controller and memory.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts stalled memory-request cycles; flags expiry on the cycle the
// count would reach MEM_TIMEOUT so the FSM can leave without an extra cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wait counter: clear has priority so a state change restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_cnt <= '0;
        else if (i_clear)    r_cnt <= '0;
        else if (i_count_en) r_cnt <= r_cnt + 1'b1;
    end

    // A zero timeout disables expiry entirely
    assign o_expired = (MEM_TIMEOUT != 0) && i_count_en && (r_cnt == LAST);
endmodule

// File: rtl/multicycle_control.sv
// Multicycle core control FSM: sequences fetch/decode/execute/memory/
// writeback, counts retired instructions and latches a sticky trap.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic        i_alu_zero,
    multicycle_control_if.master mem,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_oldpc_write,
    output logic        o_mdr_write,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic        o_pc_src,
    output logic        o_reg_write,
    output logic [1:0]  o_wb_sel,
    output logic        o_retire,
    output logic [31:0] o_instret,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause
);
    state_t      r_state, w_next;
    logic [31:0] r_instret;
    logic        r_trap;
    logic [1:0]  r_trap_cause, w_trap_cause_nxt;
    logic        w_mem_req, w_mem_we, w_mem_addr_sel;
    logic        w_expired, w_count_en, w_clear;

    // funct3 is decoded by the ALU when alu_op=FUNCT; control needs no part of it
    logic w_unused_funct3;
    assign w_unused_funct3 = ^i_funct3;

    // Count stalls straight from the state so the timer never loops through the decoder
    assign w_count_en = is_mem_wait(r_state) && !mem.mem_ready;
    assign w_clear    = (w_next != r_state);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_count_en (w_count_en),
        .o_expired  (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RESET;
        else        r_state <= w_next;
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next           = r_state;
        w_trap_cause_nxt = TRAP_NONE;
        w_mem_req        = 1'b0;
        w_mem_we         = 1'b0;
        w_mem_addr_sel   = 1'b0;
        o_ir_write       = 1'b0;
        o_pc_write       = 1'b0;
        o_oldpc_write    = 1'b0;
        o_mdr_write      = 1'b0;
        o_alu_src_a      = SRCA_PC;
        o_alu_src_b      = SRCB_RS2;
        o_alu_op         = ALU_ADD;
        o_pc_src         = PC_SRC_ALU;
        o_reg_write      = 1'b0;
        o_wb_sel         = WB_ALUOUT;
        o_retire         = 1'b0;
        case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: begin
                w_mem_req   = 1'b1;
                o_alu_src_a = SRCA_PC;
                o_alu_src_b = SRCB_FOUR;
                if (mem.mem_ready) begin
                    o_ir_write    = 1'b1;
                    o_pc_write    = 1'b1;
                    o_oldpc_write = 1'b1;
                    w_next        = S_DECODE;
                end else if (w_expired) begin
                    w_next           = S_TRAP;
                    w_trap_cause_nxt = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                // ALUOut captures OLD_PC + IMM as the branch/jump target
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                case (i_opcode)
                    OPC_LOAD, OPC_STORE: w_next = S_MEM_ADDR;
                    OPC_OP_IMM:          w_next = S_EXEC_I;
                    OPC_BRANCH:          w_next = S_BRANCH;
                    OPC_JAL:             w_next = S_JAL;
                    default: begin
                        w_next           = S_TRAP;
                        w_trap_cause_nxt = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                w_next      = (i_opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    o_mdr_write = 1'b1;
                    w_next      = S_MEM_WB;
                end else if (w_expired) begin
                    w_next           = S_TRAP;
                    w_trap_cause_nxt = TRAP_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                o_reg_write = 1'b1;
                o_wb_sel    = WB_MDR;
                o_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_req      = 1'b1;
                w_mem_we       = 1'b1;
                w_mem_addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    o_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_expired) begin
                    w_next           = S_TRAP;
                    w_trap_cause_nxt = TRAP_TIMEOUT;
                end
            end
            S_EXEC_I: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALU_FUNCT;
                w_next      = S_ALU_WB;
            end
            S_ALU_WB: begin
                o_reg_write = 1'b1;
                o_wb_sel    = WB_ALUOUT;
                o_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_RS2;
                o_alu_op    = ALU_SUB;
                if (i_alu_zero) begin
                    o_pc_write = 1'b1;
                    o_pc_src   = PC_SRC_ALUOUT;
                end
                o_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 from fetch, so it is the link value
                o_reg_write = 1'b1;
                o_wb_sel    = WB_PC;
                o_pc_write  = 1'b1;
                o_pc_src    = PC_SRC_ALUOUT;
                o_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_RESET;
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_instret <= '0;
        else if (o_retire) r_instret <= r_instret + 32'd1;
    end

    // Sticky trap flag and cause, latched on the transition into TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap       <= 1'b0;
            r_trap_cause <= TRAP_NONE;
        end else if (r_state != S_TRAP && w_next == S_TRAP) begin
            r_trap       <= 1'b1;
            r_trap_cause <= w_trap_cause_nxt;
        end
    end

    assign mem.mem_req      = w_mem_req;
    assign mem.mem_we       = w_mem_we;
    assign mem.mem_addr_sel = w_mem_addr_sel;
    assign o_instret        = r_instret;
    assign o_trap           = r_trap;
    assign o_trap_cause     = r_trap_cause;
endmodule
